// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and helpers for the seq_div restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the per-bit step counter; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and trial-subtracts
// the divisor in WIDTH+1 bits; a non-negative result is kept.
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction and restore decision.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// Optional build macro SEQ_DIV_SIGNED_EN selects two's-complement operands
// (quotient truncates toward zero, remainder follows the dividend's sign).
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | iterating one restoring step per clock, MSB first
// DONE  | one-cycle done pulse, results valid
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, prem_q, qacc_q;
    logic [WIDTH-1:0] rem_new, q_next;
    logic             q_bit;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quot_fin, rem_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic sign_a_q, sign_b_q;

    // Operand magnitudes and sign-corrected final results.
    always_comb begin
        a_mag    = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_mag    = b[WIDTH-1] ? (~b + 1'b1) : b;
        quot_fin = (sign_a_q ^ sign_b_q) ? (~q_next + 1'b1) : q_next;
        rem_fin  = sign_a_q ? (~rem_new + 1'b1) : rem_new;
    end
`else
    // Unsigned build passes operands and results straight through.
    always_comb begin
        a_mag    = a;
        b_mag    = b;
        quot_fin = q_next;
        rem_fin  = rem_new;
    end
`endif

    assign q_next = {qacc_q[WIDTH-2:0], q_bit};

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (rem_new),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (b == '0) ? DONE : RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Working registers and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            qacc_q      <= '0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            quot        <= '1;
                            rem         <= a;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd_q  <= a_mag;
                            dvs_q  <= b_mag;
                            prem_q <= '0;
                            qacc_q <= '0;
                            cnt_q  <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                            sign_a_q <= a[WIDTH-1];
                            sign_b_q <= b[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    prem_q <= rem_new;
                    qacc_q <= q_next;
                    dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        quot        <= quot_fin;
                        rem         <= rem_fin;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
